// File: rtl/nes_video_pkg.sv
// Shared NES video constants, pixel/RAM types and the dot classification helpers
// used by the line writer and its line RAM.
package nes_video_pkg;

    localparam logic [8:0] NES_VIS_W = 9'd256;
    localparam logic [8:0] NES_VIS_H = 9'd240;
    localparam logic [8:0] NES_LINES = 9'd262;
    localparam logic [8:0] NES_DOTS  = 9'd341;

    localparam int RGB_W          = 15;
    localparam int LINE_RAM_DEPTH = 512;
    localparam int LINE_RAM_AW    = 9;

    localparam logic [8:0] OVERSCAN_TOP = 9'd8;
    localparam logic [8:0] OVERSCAN_BOT = 9'd232;

    typedef logic [RGB_W-1:0]       rgb_t;
    typedef logic [LINE_RAM_AW-1:0] ram_addr_t;

    // Captured visible dot waiting for its RAM commit on the following cycle.
    typedef struct packed {
        logic      en;
        logic      last;
        ram_addr_t addr;
        rgb_t      data;
    } wr_stage_t;

    function automatic logic is_visible(logic [8:0] x, logic [8:0] y);
        return (x < NES_VIS_W) && (y < NES_VIS_H);
    endfunction

    function automatic logic in_frame(logic [8:0] x, logic [8:0] y);
        return (x < NES_DOTS) && (y < NES_LINES);
    endfunction

    function automatic logic in_overscan(logic [8:0] y);
        return (y < OVERSCAN_TOP) || (y >= OVERSCAN_BOT);
    endfunction

endpackage

// File: rtl/nes_line_writer_if.sv
// PPU pixel stream in, VGA read port and sync/status out, bundled for the line writer.
interface nes_line_writer_if;
    import nes_video_pkg::*;

    logic       pix_ce;
    rgb_t       pix_rgb;
    logic [8:0] ppu_x;
    logic [8:0] ppu_y;
    logic [9:0] rd_addr;
    rgb_t       rd_pixel;
    logic       vga_sync;
    logic       line_done;
    logic [7:0] frame_cnt;

    modport master (
        output pix_ce, pix_rgb, ppu_x, ppu_y, rd_addr,
        input  rd_pixel, vga_sync, line_done, frame_cnt
    );

    modport slave (
        input  pix_ce, pix_rgb, ppu_x, ppu_y, rd_addr,
        output rd_pixel, vga_sync, line_done, frame_cnt
    );

endinterface

// File: rtl/nes_line_ram.sv
// 512x15 simple dual-port line RAM: synchronous write, registered read that
// returns the old contents when a read and a write hit the same address.
module nes_line_ram
    import nes_video_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  ram_addr_t wr_addr,
    input  rgb_t      wr_data,
    input  ram_addr_t rd_addr,
    output rgb_t      rd_data
);

    rgb_t mem_q [LINE_RAM_DEPTH];
    rgb_t rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking write and read in the same edge give read-before-write ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/nes_line_writer.sv
// Writer side of the scan-doubled VGA line buffer: captures visible PPU dots into a
// scanline-parity banked RAM, serves the VGA read port and emits frame sync.
module nes_line_writer
    import nes_video_pkg::*;
#(
    parameter logic [8:0] SYNC_LINE     = NES_LINES - 9'd1,
    parameter logic       HIDE_OVERSCAN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    nes_line_writer_if.slave bus
);

    wr_stage_t  wr_q, wr_d;
    logic       vga_sync_q, vga_sync_d;
    logic       line_done_q, line_done_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       ram_wr_en;
    logic       unused_rd_lsb;

    // NOTE: next-state logic is combinational with blocking '='; every _d is assigned on all paths.
    always_comb begin
        wr_d.en     = bus.pix_ce && is_visible(bus.ppu_x, bus.ppu_y);
        wr_d.last   = (bus.ppu_x == NES_VIS_W - 9'd1);
        wr_d.addr   = {bus.ppu_y[0], bus.ppu_x[7:0]};
        wr_d.data   = (HIDE_OVERSCAN && in_overscan(bus.ppu_y)) ? '0 : bus.pix_rgb;
        vga_sync_d  = bus.pix_ce && in_frame(bus.ppu_x, bus.ppu_y)
                      && (bus.ppu_x == 9'd0) && (bus.ppu_y == SYNC_LINE);
        frame_cnt_d = frame_cnt_q + (vga_sync_d ? 8'd1 : 8'd0);
        line_done_d = wr_q.en && wr_q.last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q        <= '0;
            vga_sync_q  <= 1'b0;
            line_done_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            wr_q        <= wr_d;
            vga_sync_q  <= vga_sync_d;
            line_done_q <= line_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // A reset arriving while a dot is staged drops that write instead of committing it.
    assign ram_wr_en = wr_q.en && !reset;

    // Horizontal doubling: both VGA columns of a pair read the same stored pixel.
    assign unused_rd_lsb = bus.rd_addr[0];

    nes_line_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_q.addr),
        .wr_data (wr_q.data),
        .rd_addr ({bus.rd_addr[9], bus.rd_addr[8:1]}),
        .rd_data (bus.rd_pixel)
    );

    assign bus.vga_sync  = vga_sync_q;
    assign bus.line_done = line_done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: doc/nes_line_writer.md
Name: nes_line_writer

Overview:
- Writer side of the scan-doubled VGA line buffer.
- Accepts the NES PPU pixel stream (one 15-bit RGB pixel per pix_ce strobe, with the PPU dot/scanline counters) and stores visible pixels into a double-banked line RAM.
- Serves the VGA driver's read port: the driver presents next_pixel_x and gets the pixel on the following cycle.
- Emits the one-cycle frame sync pulse that re-aligns the VGA driver's counters.

Parameters:
- SYNC_LINE, 9'd261, PPU scanline on whose dot 0 the vga_sync pulse fires.
- HIDE_OVERSCAN, 1'b0, when 1 pixels on scanlines 0-7 and 232-239 are written as black.

Ports:
- clk  in  1  system clock; VGA pixel clock.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  one-cycle strobe; a PPU dot is valid this cycle.
- pix_rgb  in  15  pixel colour {b[4:0], g[4:0], r[4:0]}.
- ppu_x  in  9  PPU dot counter, 0..340.
- ppu_y  in  9  PPU scanline counter, 0..261.
- rd_addr  in  10  {bank, vga_x[8:0]} from the VGA driver's next_pixel_x.
- rd_pixel  out  15  pixel for rd_addr, registered.
- vga_sync  out  1  frame re-align pulse to the VGA driver.
- line_done  out  1  pulse: last visible pixel of a line committed.
- frame_cnt  out  8  wrapping count of vga_sync pulses.

Behaviour:
- Reset values: rd_pixel=0, vga_sync=0, line_done=0, frame_cnt=0, internal write-stage valid=0. RAM contents are not cleared.
- Visible dot: pix_ce=1 and ppu_x<256 and ppu_y<240. All other strobes cause no write.
- Write stage, 1-cycle pipeline:
  - Cycle N: a visible dot is captured as wr_en, wr_addr={ppu_y[0], ppu_x[7:0]}, wr_data.
  - Cycle N+1: the RAM write commits.
  - wr_data=0 when HIDE_OVERSCAN=1 and (ppu_y<8 or ppu_y>=232); otherwise wr_data=pix_rgb.
- RAM: 512 x 15. Bank = bit 8 of the address = PPU scanline parity.
- Horizontal doubling is on the read side. Read address is {rd_addr[9], rd_addr[8:1]}; rd_addr[0] is ignored, so each stored pixel appears twice.
- Read timing:
  - rd_pixel is valid exactly 1 cycle after rd_addr is presented; rd_addr is sampled every cycle.
  - Read-before-write: a read and a commit to the same address in the same cycle return the old data.
  - Bank selection on read belongs to the VGA driver; this block only passes rd_addr[9] through.
- vga_sync:
  - 1-cycle pulse on the cycle after pix_ce=1 with ppu_y==SYNC_LINE and ppu_x==0.
  - frame_cnt increments (mod 256) on the same cycle.
- line_done: 1-cycle pulse on the cycle the write of ppu_x==255 (visible line) commits, i.e. 2 cycles after its pix_ce.
- Counter handling:
  - pix_ce on consecutive cycles is legal; every strobe is processed.
  - Out-of-range ppu_x/ppu_y values are treated as non-visible.
- Reset mid-line: a pending write stage is dropped (wr_en cleared), outputs return to reset values in the next cycle, and no partial sync or line_done pulse is emitted.
- Simultaneous reset and pix_ce: reset wins and nothing is captured.

Decomposition:
- Shared package nes_video_pkg:
  - NES_VIS_W=256, NES_VIS_H=240, NES_LINES=262, NES_DOTS=341.
  - RGB width 15, line RAM depth 512, line RAM address width 9.
  - Overscan bounds 8 and 232.
- One sub-module: nes_line_ram.
  - Simple dual-port RAM, 512x15.
  - One synchronous write port and one registered read port with read-before-write.
  - Written so it infers block RAM.
- Top level holds the write stage, the sync and line_done logic, and frame_cnt.

Test Plan:
- Reset, then idle 10 cycles -> rd_pixel=0, vga_sync=0, line_done=0, frame_cnt=0.
- Write one line on ppu_y=4 with pix_rgb=ppu_x (ppu_x 0..255), one pix_ce every 4 clocks. Then read rd_addr={0, 2k} and {0, 2k+1} -> rd_pixel=k on the next cycle for both. line_done fires once, 2 cycles after the x=255 strobe.
- Write lines y=10 (data 15'h1111) and y=11 (data 15'h2222) -> rd_addr=10'h000 returns 15'h1111; rd_addr=10'h200 returns 15'h2222. Strobes with ppu_x=300 or ppu_y=245 leave both banks unchanged.
- Read-before-write: hold rd_addr at the address being committed with old value 15'h1111 and new value 15'h7FFF -> rd_pixel=15'h1111 that cycle, 15'h7FFF one cycle later.
- pix_ce at ppu_y=261, ppu_x=0 -> vga_sync high for exactly 1 cycle on the next cycle and frame_cnt 0->1. After 256 such events frame_cnt wraps to 0.
- HIDE_OVERSCAN=1: write y=3 and y=100 with 15'h7FFF -> the y=3 bank reads 15'h0000 and the y=100 bank reads 15'h7FFF. Assert reset in the cycle after a visible pix_ce -> that write does not commit.
